// File: rtl/pulse_rate_meter_pkg.sv
// ---------------------------------------------------------------------------
// pulse_rate_meter_pkg
// Shared constants for the pulse rate meter:
//   CLK_FREQ_DEFAULT : default board clock frequency in Hz
//   LED_W            : width of the LED bank / edge counter
//   CNT_SAT          : saturation value of the edge counter
//   gate_bits_for()  : minimum gate counter width for a given window length
// Optional feature macro used by this block: DEBOUNCE_EN
// ---------------------------------------------------------------------------
package pulse_rate_meter_pkg;

   localparam int              CLK_FREQ_DEFAULT = 12_000_000;
   localparam int              LED_W            = 8;
   localparam logic [LED_W-1:0] CNT_SAT         = 8'd255;

   // Smallest width w such that 2^w >= cycles (at least 1).
   function automatic int gate_bits_for(input int cycles);
      int bits;
      bits = 1;
      for (int i = 1; i < 31; i++) begin
         if ((64'(1) << i) < 64'(cycles)) begin
            bits = i + 1;
         end
      end
      return bits;
   endfunction

endpackage

// File: rtl/pulse_rate_meter_input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
// Brings the asynchronous SIG_IN into the CLK domain and produces a one-cycle
// rise strobe per rising edge.
// Ports:
//   CLK    in  : board clock
//   RST_N  in  : asynchronous active-low reset
//   SIG_IN in  : asynchronous external signal
//   rise   out : high for one cycle per detected rising edge
// Parameter:
//   DEBOUNCE_CYCLES : stability window of the optional filter
// Macro DEBOUNCE_EN : when defined, a debounce filter sits between s2 and s3.
// ---------------------------------------------------------------------------
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic SIG_IN,
   output logic rise
);

   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;
   logic level;   // level seen by the edge detector

`ifdef DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic            filt_q, filt_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;

   // The filtered level follows s2 only once s2 has disagreed with it for
   // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_comb begin
      filt_d   = filt_q;
      db_cnt_d = '0;
      if (s2_q != filt_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            filt_d = s2_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         filt_q   <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         filt_q   <= filt_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign level = filt_q;
`else
   assign level = s2_q;
`endif

   always_comb begin
      s1_d = SIG_IN;
      s2_d = s1_q;
      s3_d = level;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign rise = level & ~s3_q;

endmodule

// File: rtl/pulse_rate_meter.sv
// ---------------------------------------------------------------------------
// pulse_rate_meter
// Counts rising edges of SIG_IN over a fixed gate window of GATE_CYCLES
// clocks and latches the (saturated) count onto the LED bank at window end.
// Ports:
//   CLK     in  : board clock
//   RST_N   in  : asynchronous active-low reset
//   SIG_IN  in  : asynchronous external signal to measure
//   LED_OUT out : edge count of the last completed window (bit 7 = MSB)
//   VALID   out : one-cycle pulse when LED_OUT is updated
//   OVF     out : last completed window had more than 255 edges
// Macro DEBOUNCE_EN : enables the debounce filter in the input conditioner.
// ---------------------------------------------------------------------------
module pulse_rate_meter
   import pulse_rate_meter_pkg::*;
#(
   parameter int CLK_FREQ        = CLK_FREQ_DEFAULT,
   parameter int GATE_CYCLES     = CLK_FREQ,
   parameter int GATE_BITS       = 24,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             SIG_IN,
   output logic [LED_W-1:0] LED_OUT,
   output logic             VALID,
   output logic             OVF
);

   logic                 rise;
   logic [GATE_BITS-1:0] gate_cnt_q, gate_cnt_d;
   logic [LED_W-1:0]     edge_cnt_q, edge_cnt_d;
   logic                 sticky_q, sticky_d;
   logic [LED_W-1:0]     led_q, led_d;
   logic                 valid_q, valid_d;
   logic                 ovf_q, ovf_d;

   logic                 gate_end;
   logic                 edge_at_max;
   logic [LED_W-1:0]     edge_sum;

   input_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_cond (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .SIG_IN (SIG_IN),
      .rise   (rise)
   );

   assign gate_end    = (gate_cnt_q == GATE_BITS'(GATE_CYCLES - 1));
   assign edge_at_max = (edge_cnt_q == CNT_SAT);
   // Count including this cycle's rise, clamped at the saturation value.
   assign edge_sum    = (rise && !edge_at_max) ? edge_cnt_q + LED_W'(1) : edge_cnt_q;

   always_comb begin
      gate_cnt_d = gate_end ? '0 : gate_cnt_q + GATE_BITS'(1);
      edge_cnt_d = edge_sum;
      // Includes a rise on the final cycle so the window-end OVF sees it.
      sticky_d   = sticky_q | (rise & edge_at_max);
      led_d      = led_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;
      if (gate_end) begin
         led_d      = edge_sum;
         ovf_d      = sticky_d;
         valid_d    = 1'b1;
         // Nothing, including a final-cycle rise, carries into the next window.
         edge_cnt_d = '0;
         sticky_d   = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         sticky_q   <= 1'b0;
         led_q      <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         sticky_q   <= sticky_d;
         led_q      <= led_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
      end
   end

   assign LED_OUT = led_q;
   assign VALID   = valid_q;
   assign OVF     = ovf_q;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// ---------------------------------------------------------------------------
// tb_pulse_rate_meter
// Self-checking bench: one 100-cycle-window instance for the main scenarios
// and one 600-cycle-window instance for saturation. Expected window results
// are queued as stimulus is driven and popped when VALID is observed.
// ---------------------------------------------------------------------------
module tb_pulse_rate_meter;

   typedef struct packed {
      logic [7:0] led;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sig_in = 1'b0;
   logic       sat_sig = 1'b0;
   logic [7:0] led, sat_led;
   logic       valid, ovf, sat_valid, sat_ovf;

   int   cyc = 0;
   int   last_at = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   exp_t sat_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pulse_rate_meter #(
      .CLK_FREQ(100), .GATE_CYCLES(100), .GATE_BITS(8), .DEBOUNCE_CYCLES(4)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .SIG_IN(sig_in),
      .LED_OUT(led), .VALID(valid), .OVF(ovf)
   );

   pulse_rate_meter #(
      .CLK_FREQ(600), .GATE_CYCLES(600), .GATE_BITS(10), .DEBOUNCE_CYCLES(4)
   ) dut_sat (
      .CLK(clk), .RST_N(rst_n), .SIG_IN(sat_sig),
      .LED_OUT(sat_led), .VALID(sat_valid), .OVF(sat_ovf)
   );

   task automatic pulses(input int n, input int hi, input int lo);
      for (int i = 0; i < n; i++) begin
         sig_in = 1'b1;
         repeat (hi) @(negedge clk);
         sig_in = 1'b0;
         repeat (lo) @(negedge clk);
      end
   endtask

   task automatic sat_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         sat_sig = 1'b1;
         @(negedge clk);
         sat_sig = 1'b0;
         @(negedge clk);
      end
   endtask

   // Returns the cycle at which VALID was seen, or -1 if the bound expired.
   task automatic wait_valid(input int bound, output int at_cyc);
      int n;
      n = 0;
      at_cyc = -1;
      while (n < bound && at_cyc < 0) begin
         @(negedge clk);
         n++;
         if (valid === 1'b1) at_cyc = cyc;
      end
   endtask

   task automatic wait_sat_valid(input int bound, output int at_cyc);
      int n;
      n = 0;
      at_cyc = -1;
      while (n < bound && at_cyc < 0) begin
         @(negedge clk);
         n++;
         if (sat_valid === 1'b1) at_cyc = cyc;
      end
   endtask

   task automatic test_reset();
      int   bad, at, rel;
      exp_t e;
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         sig_in = ~sig_in;
      end
      n_checks++;
      if (led !== 8'd0 || valid !== 1'b0 || ovf !== 1'b0)
         $display("FAIL reset_hold: got led=%0d valid=%b ovf=%b, want 0 0 0", led, valid, ovf);
      // High across release: exactly one rise belongs to the first window.
      sig_in = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      rel = cyc;
      exp_q.push_back('{led: 8'd1, ovf: 1'b0});
      bad = 0;
      for (int i = 0; i < 99; i++) begin
         @(negedge clk);
         if (i == 5) sig_in = 1'b0;
         if (valid !== 1'b0 || led !== 8'd0 || ovf !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL reset_quiet: got %0d non-idle cycles, want 0", bad);
      end
      wait_valid(10, at);
      e = exp_q.pop_front();
      $display("txn reset: cycle=%0d led=%0d ovf=%b exp_led=%0d exp_ovf=%b", at - rel, led, ovf, e.led, e.ovf);
      n_checks++;
      if (at !== rel + 100) begin
         n_fail++;
         $display("FAIL reset_first_valid: got cycle %0d, want %0d", at - rel, 100);
      end
      n_checks++;
      if (led !== e.led || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL reset_window: got led=%0d ovf=%b, want led=%0d ovf=%b", led, ovf, e.led, e.ovf);
      end
      last_at = at;
   endtask

   task automatic test_counting();
      int   at;
      exp_t e;
      exp_q.push_back('{led: 8'd10, ovf: 1'b0});
      pulses(10, 3, 5);
      wait_valid(110, at);
      e = exp_q.pop_front();
      $display("txn counting: cycle=%0d led=%0d ovf=%b exp_led=%0d exp_ovf=%b", at, led, ovf, e.led, e.ovf);
      n_checks++;
      if (at !== last_at + 100) begin
         n_fail++;
         $display("FAIL counting_period: got %0d, want %0d", at - last_at, 100);
      end
      n_checks++;
      if (led !== e.led || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL counting_10: got led=%0d ovf=%b, want led=%0d ovf=%b", led, ovf, e.led, e.ovf);
      end
      last_at = at;
      @(negedge clk);
      n_checks++;
      if (valid !== 1'b0 || led !== e.led) begin
         n_fail++;
         $display("FAIL valid_one_cycle: got valid=%b led=%0d, want valid=0 led=%0d", valid, led, e.led);
      end
      exp_q.push_back('{led: 8'd0, ovf: 1'b0});
      wait_valid(110, at);
      e = exp_q.pop_front();
      $display("txn counting_idle: cycle=%0d led=%0d ovf=%b exp_led=%0d exp_ovf=%b", at, led, ovf, e.led, e.ovf);
      n_checks++;
      if (at !== last_at + 100 || led !== e.led || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL counting_idle: got period=%0d led=%0d ovf=%b, want period=100 led=%0d ovf=%b",
                  at - last_at, led, ovf, e.led, e.ovf);
      end
      last_at = at;
   endtask

   task automatic test_boundary();
      int   at, v;
      exp_t e;
      v = last_at;
      exp_q.push_back('{led: 8'd4, ovf: 1'b0});
      pulses(3, 3, 5);
      while (cyc < v + 97) @(negedge clk);
      // Sampled at edge v+98, on s2 after v+99, counted at the window-end edge v+100.
      sig_in = 1'b1;
      repeat (2) @(negedge clk);
      sig_in = 1'b0;
      wait_valid(20, at);
      e = exp_q.pop_front();
      $display("txn boundary: cycle=%0d led=%0d ovf=%b exp_led=%0d exp_ovf=%b", at, led, ovf, e.led, e.ovf);
      n_checks++;
      if (at !== v + 100 || led !== e.led || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL boundary_last_cycle: got period=%0d led=%0d ovf=%b, want period=100 led=%0d ovf=%b",
                  at - v, led, ovf, e.led, e.ovf);
      end
      last_at = at;
      exp_q.push_back('{led: 8'd0, ovf: 1'b0});
      wait_valid(110, at);
      e = exp_q.pop_front();
      $display("txn boundary_next: cycle=%0d led=%0d ovf=%b exp_led=%0d exp_ovf=%b", at, led, ovf, e.led, e.ovf);
      n_checks++;
      if (at !== last_at + 100 || led !== e.led || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL boundary_no_carry: got period=%0d led=%0d ovf=%b, want period=100 led=%0d ovf=%b",
                  at - last_at, led, ovf, e.led, e.ovf);
      end
      last_at = at;
   endtask

   task automatic test_mid_reset();
      int   at, v, rel, bad;
      exp_t e;
      v = last_at;
      exp_q.push_back('{led: 8'd9, ovf: 1'b0});
      pulses(9, 2, 4);
      wait_valid(110, at);
      e = exp_q.pop_front();
      $display("txn mid_reset_pre: cycle=%0d led=%0d ovf=%b exp_led=%0d exp_ovf=%b", at, led, ovf, e.led, e.ovf);
      n_checks++;
      if (at !== v + 100 || led !== e.led || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL mid_reset_pre: got period=%0d led=%0d ovf=%b, want period=100 led=%0d ovf=%b",
                  at - v, led, ovf, e.led, e.ovf);
      end
      v = at;
      pulses(7, 2, 4);
      while (cyc < v + 50) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (led !== 8'd0 || valid !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_async: got led=%0d valid=%b ovf=%b, want 0 0 0", led, valid, ovf);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rel = cyc;
      exp_q.push_back('{led: 8'd0, ovf: 1'b0});
      bad = 0;
      for (int i = 0; i < 99; i++) begin
         @(negedge clk);
         if (valid !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL mid_reset_no_early_valid: got %0d VALID cycles, want 0", bad);
      end
      wait_valid(10, at);
      e = exp_q.pop_front();
      $display("txn mid_reset: cycle=%0d led=%0d ovf=%b exp_led=%0d exp_ovf=%b", at - rel, led, ovf, e.led, e.ovf);
      n_checks++;
      if (at !== rel + 100 || led !== e.led || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL mid_reset_discard: got cycle=%0d led=%0d ovf=%b, want cycle=100 led=%0d ovf=%b",
                  at - rel, led, ovf, e.led, e.ovf);
      end
      last_at = at;
   endtask

   task automatic test_saturation();
      int   at, v;
      int   n_rise[4];
      exp_t e;
      n_rise = '{290, 5, 255, 256};
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      v = cyc;
      for (int w = 0; w < 4; w++) begin
         sat_q.push_back('{led: (n_rise[w] > 255) ? 8'd255 : 8'(n_rise[w]), ovf: (n_rise[w] > 255)});
         sat_pulses(n_rise[w]);
         wait_sat_valid(610, at);
         e = sat_q.pop_front();
         $display("txn saturation[%0d]: rises=%0d cycle=%0d led=%0d ovf=%b exp_led=%0d exp_ovf=%b",
                  w, n_rise[w], at - v, sat_led, sat_ovf, e.led, e.ovf);
         n_checks++;
         if (at !== v + 600 || sat_led !== e.led || sat_ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL saturation_%0d: got period=%0d led=%0d ovf=%b, want period=600 led=%0d ovf=%b",
                     n_rise[w], at - v, sat_led, sat_ovf, e.led, e.ovf);
         end
         v = at;
      end
   endtask

   task automatic test_debounce();
      int   at, v;
      exp_t e;
      v = last_at;
      exp_q.push_back('{led: 8'd0, ovf: 1'b0});
      pulses(5, 2, 6);
      wait_valid(110, at);
      e = exp_q.pop_front();
      $display("txn debounce_glitch: cycle=%0d led=%0d ovf=%b exp_led=%0d exp_ovf=%b", at, led, ovf, e.led, e.ovf);
      n_checks++;
      if (at !== v + 100 || led !== e.led || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL debounce_glitch: got period=%0d led=%0d ovf=%b, want period=100 led=%0d ovf=%b",
                  at - v, led, ovf, e.led, e.ovf);
      end
      v = at;
      exp_q.push_back('{led: 8'd5, ovf: 1'b0});
      pulses(5, 6, 6);
      wait_valid(110, at);
      e = exp_q.pop_front();
      $display("txn debounce_wide: cycle=%0d led=%0d ovf=%b exp_led=%0d exp_ovf=%b", at, led, ovf, e.led, e.ovf);
      n_checks++;
      if (at !== v + 100 || led !== e.led || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL debounce_wide: got period=%0d led=%0d ovf=%b, want period=100 led=%0d ovf=%b",
                  at - v, led, ovf, e.led, e.ovf);
      end
      last_at = at;
   endtask

   initial begin
      test_reset();
`ifdef DEBOUNCE_EN
      test_debounce();
`else
      test_counting();
      test_boundary();
      test_mid_reset();
      test_saturation();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog expired");
   end

endmodule
